// File: rtl/scs8hd_lpflow_pkg.sv
// -----------------------------------------------------------------------------
// scs8hd_lpflow_pkg
// Types and constants shared by the power-domain isolation sequencer and its
// delay counter.
//   lpflow_seq_state_t : sequencer states, in power-down then power-up order
//   LPFLOW_CNT_W       : width of the shared settle/timeout counter
// -----------------------------------------------------------------------------
package scs8hd_lpflow_pkg;

  localparam int LPFLOW_CNT_W = 16;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    ISO_ON  = 3'd1,
    SAVE    = 3'd2,
    PWROFF  = 3'd3,
    OFF     = 3'd4,
    PWRUP   = 3'd5,
    RESTORE = 3'd6,
    ISO_OFF = 3'd7
  } lpflow_seq_state_t;

endpackage

// File: rtl/scs8hd_lpflow_dly_cnt.sv
// -----------------------------------------------------------------------------
// scs8hd_lpflow_dly_cnt
// Loadable down-counter shared by every timed state of the sequencer.
// A load takes priority; otherwise the count decrements and parks at 0.
// done is high while the count reads 1, i.e. on the last cycle of a wait
// of load_val cycles.
// Ports:
//   clk      : clock
//   rst      : asynchronous active-high reset, count returns to RST_VAL
//   load     : load load_val this cycle
//   load_val : value to load
//   done     : count == 1
// -----------------------------------------------------------------------------
module scs8hd_lpflow_dly_cnt
  import scs8hd_lpflow_pkg::*;
#(
  parameter logic [LPFLOW_CNT_W-1:0] RST_VAL = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [LPFLOW_CNT_W-1:0] load_val,
  output logic                    done
);

  logic [LPFLOW_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == LPFLOW_CNT_W'(1));

endmodule

// File: rtl/scs8hd_lpflow_iso_seq.sv
// -----------------------------------------------------------------------------
// scs8hd_lpflow_iso_seq
// Always-on power-domain sequencer. Orders isolate -> save -> power-off on a
// sleep request and power-on -> restore -> de-isolate on a wake request.
// Optional macro SCS8HD_LPFLOW_RET_EN: when defined the SAVE/RESTORE states
// emit one-cycle retention strobes; when undefined they are skipped and the
// strobes are tied low.
// Handshake: sleep_req is a level, sampled only in RUN and OFF; sleep_ack /
// run_ack are levels that hold for as long as the FSM rests in OFF / RUN.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (state -> PWRUP)
//   sleep_req    : 1 = domain should sleep, 0 = run
//   pwr_good     : switched-rail good, synchronous to clk
//   sleepb       : isolation control, 0 = isolate
//   pwr_en       : header switch enable
//   ret_save     : one-cycle retention save strobe
//   ret_restore  : one-cycle retention restore strobe
//   sleep_ack    : resting in OFF
//   run_ack      : resting in RUN
//   busy         : in a transit state
//   pg_timeout   : sticky, power-good never arrived during a wake
//   dbg_state    : current FSM state
// All outputs are registered: they are decoded from the next state and
// captured together with it.
// -----------------------------------------------------------------------------
module scs8hd_lpflow_iso_seq
  import scs8hd_lpflow_pkg::*;
#(
  parameter int ISO_SETTLE = 4,
  parameter int PG_TIMEOUT = 64,
  parameter int OFF_SETTLE = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sleep_req,
  input  logic              pwr_good,
  output logic              sleepb,
  output logic              pwr_en,
  output logic              ret_save,
  output logic              ret_restore,
  output logic              sleep_ack,
  output logic              run_ack,
  output logic              busy,
  output logic              pg_timeout,
  output lpflow_seq_state_t dbg_state
);

  localparam logic [LPFLOW_CNT_W-1:0] ISO_V = LPFLOW_CNT_W'(ISO_SETTLE);
  localparam logic [LPFLOW_CNT_W-1:0] PG_V  = LPFLOW_CNT_W'(PG_TIMEOUT);
  localparam logic [LPFLOW_CNT_W-1:0] OFF_V = LPFLOW_CNT_W'(OFF_SETTLE);

  lpflow_seq_state_t       state_q, state_d;
  logic                    cnt_load, cnt_done;
  logic [LPFLOW_CNT_W-1:0] cnt_val;
  // wake_arm: OFF may start a wake. Cleared when a wake times out so that a
  // fresh 1 -> 0 edge on sleep_req is needed before the next attempt.
  logic                    wake_arm_q, wake_arm_d;
  logic                    pg_timeout_d;
  logic sleepb_d, pwr_en_d, ret_save_d, ret_restore_d;
  logic sleep_ack_d, run_ack_d, busy_d;

  // Reset lands in PWRUP, so the counter comes out of reset holding the
  // power-good timeout.
  scs8hd_lpflow_dly_cnt #(.RST_VAL(PG_V)) u_dly_cnt (
    .clk      (clk),
    .rst      (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_comb begin
    state_d      = state_q;
    wake_arm_d   = wake_arm_q;
    pg_timeout_d = pg_timeout;
    case (state_q)
      RUN: if (sleep_req) state_d = ISO_ON;
      ISO_ON: begin
        if (cnt_done) begin
`ifdef SCS8HD_LPFLOW_RET_EN
          state_d = SAVE;
`else
          state_d = PWROFF;
`endif
        end
      end
      SAVE: state_d = PWROFF;
      PWROFF: begin
        if (cnt_done) begin
          state_d    = OFF;
          wake_arm_d = 1'b1;
        end
      end
      OFF: begin
        if (sleep_req) begin
          wake_arm_d = 1'b1;
        end else if (wake_arm_q) begin
          state_d = PWRUP;
        end
      end
      PWRUP: begin
        // pwr_good wins over an expiring timeout in the same cycle.
        if (pwr_good) begin
`ifdef SCS8HD_LPFLOW_RET_EN
          state_d = RESTORE;
`else
          state_d = ISO_OFF;
`endif
        end else if (cnt_done) begin
          state_d      = OFF;
          pg_timeout_d = 1'b1;
          wake_arm_d   = 1'b0;
        end
      end
      RESTORE: state_d = ISO_OFF;
      ISO_OFF: if (cnt_done) state_d = RUN;
      default: state_d = PWRUP;
    endcase
  end

  // Counter loads on every state entry with that state's wait length.
  always_comb begin
    cnt_load = (state_d != state_q);
    cnt_val  = LPFLOW_CNT_W'(1);
    case (state_d)
      ISO_ON, ISO_OFF: cnt_val = ISO_V;
      PWROFF:          cnt_val = OFF_V;
      PWRUP:           cnt_val = PG_V;
      default:         cnt_val = LPFLOW_CNT_W'(1);
    endcase
  end

  always_comb begin
    sleepb_d      = (state_d == RUN) || (state_d == ISO_OFF);
    pwr_en_d      = !((state_d == PWROFF) || (state_d == OFF));
`ifdef SCS8HD_LPFLOW_RET_EN
    ret_save_d    = (state_d == SAVE);
    ret_restore_d = (state_d == RESTORE);
`else
    ret_save_d    = 1'b0;
    ret_restore_d = 1'b0;
`endif
    sleep_ack_d   = (state_d == OFF);
    run_ack_d     = (state_d == RUN);
    busy_d        = !((state_d == RUN) || (state_d == OFF));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PWRUP;
      wake_arm_q  <= 1'b0;
      sleepb      <= 1'b0;
      pwr_en      <= 1'b1;
      ret_save    <= 1'b0;
      ret_restore <= 1'b0;
      sleep_ack   <= 1'b0;
      run_ack     <= 1'b0;
      busy        <= 1'b1;
      pg_timeout  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wake_arm_q  <= wake_arm_d;
      sleepb      <= sleepb_d;
      pwr_en      <= pwr_en_d;
      ret_save    <= ret_save_d;
      ret_restore <= ret_restore_d;
      sleep_ack   <= sleep_ack_d;
      run_ack     <= run_ack_d;
      busy        <= busy_d;
      pg_timeout  <= pg_timeout_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_scs8hd_lpflow_iso_seq.sv
// -----------------------------------------------------------------------------
// tb_scs8hd_lpflow_iso_seq
// Directed sequence with randomized delays. Expected output vectors
// {sleepb,pwr_en,ret_save,ret_restore,sleep_ack,run_ack,busy,pg_timeout} are
// derived from the cycle offset into each sleep or wake sequence; a monitor
// checks the ordering invariants on every cycle.
// -----------------------------------------------------------------------------
module tb_scs8hd_lpflow_iso_seq;
  import scs8hd_lpflow_pkg::*;

  localparam int ISO  = 4;
  localparam int OFFS = 8;
  localparam int PGT  = 64;
`ifdef SCS8HD_LPFLOW_RET_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif

  logic clk = 1'b0;
  logic reset, sleep_req, pwr_good;
  logic sleepb, pwr_en, ret_save, ret_restore, sleep_ack, run_ack, busy, pg_timeout;
  lpflow_seq_state_t dbg_state;
  logic [7:0] obs_v;

  int vectors = 0;
  int miscompares = 0;

  scs8hd_lpflow_iso_seq dut (
    .clk         (clk),
    .reset       (reset),
    .sleep_req   (sleep_req),
    .pwr_good    (pwr_good),
    .sleepb      (sleepb),
    .pwr_en      (pwr_en),
    .ret_save    (ret_save),
    .ret_restore (ret_restore),
    .sleep_ack   (sleep_ack),
    .run_ack     (run_ack),
    .busy        (busy),
    .pg_timeout  (pg_timeout),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  assign obs_v = {sleepb, pwr_en, ret_save, ret_restore, sleep_ack, run_ack, busy, pg_timeout};

  // ---------------- reference model ----------------
  localparam logic [7:0] V_RESET = 8'b0100_0010;

  // n = cycles since the sleep request was first seen (n=1 is first state).
  function automatic logic [7:0] exp_sleep(int n, bit pgt);
    if (n <= ISO)                 return {7'b0100_001, pgt};
    else if (R == 1 && n == ISO + 1) return {7'b0110_001, pgt};
    else if (n <= ISO + R + OFFS) return {7'b0000_001, pgt};
    else                          return {7'b0000_100, pgt};
  endfunction

  // n = cycles since the wake started (n=1 is PWRUP); d = cycles of PWRUP.
  function automatic logic [7:0] exp_wake(int n, int d, bit pgt);
    if (n <= d)                    return {7'b0100_001, pgt};
    else if (R == 1 && n == d + 1) return {7'b0101_001, pgt};
    else if (n <= d + R + ISO)     return {7'b1100_001, pgt};
    else                           return {7'b1100_010, pgt};
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] e);
    vectors++;
    assert (obs_v === e) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs_v, e);
    end
  endtask

  task automatic chk_state(input string tag, input lpflow_seq_state_t e);
    vectors++;
    assert (dbg_state === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, dbg_state, e);
    end
  endtask

  // Walks a sleep sequence; optionally drops sleep_req at offset toggle_at.
  task automatic run_sleep(input bit pgt, input int toggle_at, input int stop_at);
    int last;
    last = (stop_at > 0) ? stop_at : ISO + R + OFFS + 1;
    sleep_req = 1'b1;
    for (int n = 1; n <= last; n++) begin
      step();
      chk("sleep_seq", exp_sleep(n, pgt));
      if (n == toggle_at) sleep_req = 1'b0;
    end
    if (stop_at == 0) pwr_good = 1'b0;
  endtask

  // Checks a wake from its first PWRUP cycle; pwr_good is raised so that it
  // is first seen after d PWRUP cycles.
  task automatic wake_chk(input int d, input bit pgt);
    if (d == 0) pwr_good = 1'b1;
    for (int n = 1; n <= d + R + ISO + 2; n++) begin
      step();
      chk("wake_seq", exp_wake(n, d, pgt));
      if (n == d) pwr_good = 1'b1;
    end
  endtask

  task automatic run_wake(input int d, input bit pgt);
    sleep_req = 1'b0;
    wake_chk(d, pgt);
  endtask

  // ---------------- invariant monitor ----------------
  logic prev_sleepb = 1'b0;
  logic restored = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      restored = 1'b0;
    end else begin
      vectors++;
      assert (!(pwr_en === 1'b0 && sleepb !== 1'b0)) else begin
        miscompares++;
        $error("FAIL inv_iso_when_off observed=%b expected=0", sleepb);
      end
      vectors++;
      assert (!(ret_save === 1'b1 && pwr_en !== 1'b1)) else begin
        miscompares++;
        $error("FAIL inv_save_powered observed=%b expected=1", pwr_en);
      end
      if (pwr_en === 1'b0) restored = 1'b0;
      if (R == 1 && sleepb === 1'b1 && prev_sleepb === 1'b0) begin
        vectors++;
        assert (restored === 1'b1) else begin
          miscompares++;
          $error("FAIL inv_restore_first observed=%b expected=1", restored);
        end
      end
      if (ret_restore === 1'b1) restored = 1'b1;
    end
    prev_sleepb = sleepb;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int d, k;
    reset = 1'b1; sleep_req = 1'b0; pwr_good = 1'b1;
    repeat (3) step();
    chk("reset_vals", V_RESET);
    chk_state("reset_state", PWRUP);

    // Release with power already good: RESTORE, de-isolate, RUN.
    reset = 1'b0;
    wake_chk(0, 1'b0);

    // Randomized sleep / wake rounds.
    for (int it = 0; it < 3; it++) begin
      run_sleep(1'b0, 0, 0);
      k = $urandom_range(1, 6);
      repeat (k) begin
        step();
        chk("off_hold", exp_sleep(ISO + R + OFFS + 1, 1'b0));
      end
      d = $urandom_range(1, 30);
      if (it == 0) d = 10;
      run_wake(d, 1'b0);
      k = $urandom_range(1, 6);
      repeat (k) begin
        step();
        chk("run_hold", exp_wake(d + R + ISO + 1, d, 1'b0));
      end
    end

    // Wake with pwr_good stuck low: timeout back to OFF.
    run_sleep(1'b0, 0, 0);
    sleep_req = 1'b0;
    for (int n = 1; n <= PGT + 1; n++) begin
      step();
      chk("pg_timeout_seq", (n <= PGT) ? 8'b0100_0010 : 8'b0000_1001);
    end
    // No retry while sleep_req stays low.
    repeat (5) begin
      step();
      chk("timeout_hold", 8'b0000_1001);
    end
    sleep_req = 1'b1;
    repeat (2) begin
      step();
      chk("timeout_rearm", 8'b0000_1001);
    end
    d = $urandom_range(1, 30);
    run_wake(d, 1'b1);

    // Reset asserted mid PWROFF.
    run_sleep(1'b1, 0, ISO + R + 3);
    #2 reset = 1'b1;
    #1;
    chk("reset_async", V_RESET);
    chk_state("reset_async_state", PWRUP);
    sleep_req = 1'b0;
    pwr_good = 1'b0;
    repeat (2) begin
      step();
      chk("reset_hold", V_RESET);
    end
    reset = 1'b0;
    d = $urandom_range(3, 20);
    wake_chk(d, 1'b0);

    // Request reversed during ISO_ON: completes to OFF then wakes.
    run_sleep(1'b0, 2, 0);
    d = $urandom_range(1, 30);
    wake_chk(d, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
